// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and emits them one bit per
// clock with a valid strobe, a last-bit pulse and an optional idle gap between words.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntPrev = CntW'(WIDTH - 2);
  localparam logic [3:0]      GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             word_done_q, word_done_d;

  logic last_bit;
  logic accept;

  assign last_bit = (state_q == StShift) && (cnt_q == CntLast);
  assign accept   = din_valid && din_ready;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      word_done_q  <= word_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (last_bit) begin
          if (accept)        state_d = StShift;
          else if (GAP == 0) state_d = StIdle;
          else               state_d = StGap;
        end
      end
      StGap: begin
        if (gcnt_q == GapLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    din_ready    = !RST && ((state_q == StIdle) || (last_bit && (GAP == 0)));
    busy         = (state_q != StIdle);
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    sout_d       = IDLE_BIT;
    sout_valid_d = 1'b0;
    word_done_d  = 1'b0;

    if (accept) begin
      sr_d         = din;
      cnt_d        = '0;
      sout_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
      sout_valid_d = 1'b1;
    end else begin
      unique case (state_q)
        StShift: begin
          if (!last_bit) begin
            // The bit adjacent to the output end becomes the next serial bit.
            if (MSB_FIRST) begin
              sr_d   = {sr_q[WIDTH-2:0], 1'b0};
              sout_d = sr_q[WIDTH-2];
            end else begin
              sr_d   = {1'b0, sr_q[WIDTH-1:1]};
              sout_d = sr_q[1];
            end
            cnt_d        = cnt_q + CntW'(1);
            sout_valid_d = 1'b1;
            word_done_d  = (cnt_q == CntPrev);
          end else begin
            gcnt_d = '0;
          end
        end
        StGap: begin
          gcnt_d = gcnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first/no gap, LSB-first/gap 2) driven in
// lockstep and compared each cycle against a queue-of-future-outputs reference model.
module tb_bit_serializer;

  localparam int unsigned Width = 8;
  localparam int unsigned QLen  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             din_valid;
  logic [Width-1:0] din;
  logic [1:0]       din_ready, sout, sout_valid, word_done, busy;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) u_dut0 (
    .CLK(clk), .RST(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .sout(sout[0]), .sout_valid(sout_valid[0]), .word_done(word_done[0]), .busy(busy[0])
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(2)) u_dut1 (
    .CLK(clk), .RST(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .sout(sout[1]), .sout_valid(sout_valid[1]), .word_done(word_done[1]), .busy(busy[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: each accepted word becomes a list of future output cycles.
  // Entry encoding: [3] gap cycle, [2] last bit, [1] valid, [0] data bit.
  int         msb_first [2] = '{1, 0};
  int         gap_len   [2] = '{0, 2};
  logic       idle_lvl  [2] = '{1'b0, 1'b1};
  logic [3:0] mq [2][QLen];
  int         head [2] = '{0, 0};
  int         tail [2] = '{0, 0};
  logic [3:0] cur  [2] = '{4'd0, 4'd0};
  logic       rdy  [2];
  logic [31:0] log_bits [2];

  function automatic logic model_ready(input int k);
    logic idle_now;
    idle_now = !cur[k][1] && !cur[k][3];
    return !rst && (head[k] == tail[k]) && (idle_now || (cur[k][2] && gap_len[k] == 0));
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        head[k] = 0;
        tail[k] = 0;
        cur[k]  = 4'd0;
      end else begin
        if (din_valid && rdy[k]) begin
          for (int i = 0; i < Width; i++) begin
            logic b;
            b = (msb_first[k] != 0) ? din[Width-1-i] : din[i];
            mq[k][tail[k] % QLen] = {1'b0, (i == Width - 1), 1'b1, b};
            tail[k]++;
          end
          for (int g = 0; g < gap_len[k]; g++) begin
            mq[k][tail[k] % QLen] = 4'b1000;
            tail[k]++;
          end
        end
        if (head[k] != tail[k]) begin
          cur[k] = mq[k][head[k] % QLen];
          head[k]++;
        end else begin
          cur[k] = 4'd0;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [Width-1:0] d);
    rst       = r;
    din_valid = v;
    din       = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = model_ready(k);
      check_eq($sformatf("din_ready[%0d]", k), 32'(din_ready[k]), 32'(rdy[k]));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic exp_sout;
      exp_sout = cur[k][1] ? cur[k][0] : idle_lvl[k];
      check_eq($sformatf("outs[%0d] {busy,done,valid,sout}", k),
               32'({busy[k], word_done[k], sout_valid[k], sout[k]}),
               32'({cur[k][1] | cur[k][3], cur[k][2], cur[k][1], exp_sout}));
      if (sout_valid[k]) log_bits[k] = {log_bits[k][30:0], sout[k]};
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, Width'($urandom));
  endtask

  task automatic clear_logs();
    log_bits[0] = '0;
    log_bits[1] = '0;
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    @(negedge clk);

    // Reset with a valid word pending: nothing may be accepted.
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hFF);
    check_eq("reset sout0", 32'(sout[0]), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);

    // Single word.
    clear_logs();
    cyc(1'b0, 1'b1, 8'hA5);
    idle_cycles(12);
    check_eq("single A5 msb", log_bits[0], 32'h0000_00A5);
    check_eq("single A5 lsb", log_bits[1], 32'h0000_00A5);

    // Back-to-back with din_valid held.
    clear_logs();
    cyc(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h3C);
    idle_cycles(14);
    check_eq("b2b stream", log_bits[0], 32'h0000_A53C);

    // Gap spacing, LSB-first.
    clear_logs();
    cyc(1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 8'h80);
    idle_cycles(14);
    check_eq("gap stream lsb", log_bits[1], 32'h0000_8001);
    check_eq("gap stream msb", log_bits[0], 32'h0000_0180);

    // Reset after three bits, then a clean word.
    cyc(1'b0, 1'b1, 8'hFF);
    idle_cycles(3);
    cyc(1'b1, 1'b0, 8'h00);
    check_eq("mid reset valid", 32'(sout_valid), 32'd0);
    check_eq("mid reset done", 32'(word_done), 32'd0);
    clear_logs();
    cyc(1'b0, 1'b1, 8'h0F);
    idle_cycles(12);
    check_eq("post reset msb", log_bits[0], 32'h0000_000F);
    check_eq("post reset lsb", log_bits[1], 32'h0000_00F0);

    // Pattern fed to the sequence detector.
    clear_logs();
    cyc(1'b0, 1'b1, 8'b1001_0010);
    idle_cycles(12);
    check_eq("detector word", log_bits[0], 32'h0000_0092);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), Width'($urandom));
    end
    idle_cycles(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial stage that produces the single-bit stream consumed by the sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. Each serial bit is qualified by a valid strobe. An optional idle gap can be inserted between words, so bench and system code can build arbitrary bit patterns from bytes.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_BIT, 0, level driven on sout whenever sout_valid = 0.
- GAP, 0, number of idle cycles after each word; legal range 0..15.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  reset, synchronous and active-high.
- din  input  WIDTH  parallel word; sampled only on an accepting edge.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  serializer can accept a word this cycle.
- sout  output  1  serial bit; registered.
- sout_valid  output  1  sout carries a data bit; registered.
- word_done  output  1  one-cycle pulse, high in the same cycle as the last bit of a word; registered.
- busy  output  1  state != IDLE.

## Operation
- State machine has three states: IDLE, SHIFT, GAP. Internal signals:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, width clog2(WIDTH).
  - gap counter gcnt, 4 bits.
- Acceptance happens at a rising edge where din_valid = 1 and din_ready = 1. On acceptance:
  - sr loads din, cnt clears to 0, state goes to SHIFT.
  - sout gets the first bit: din[WIDTH-1] if MSB_FIRST, else din[0].
  - sout_valid is set to 1.
- din_ready is combinational and equals !RST && (state == IDLE || (state == SHIFT && cnt == WIDTH-1 && GAP == 0)).
- SHIFT behaviour, for each edge with cnt < WIDTH-1:
  - sr shifts by one bit toward the output end.
  - sout takes the next bit and cnt increments.
  - sout_valid stays 1.
- word_done is high in the cycle where cnt == WIDTH-1, which is the cycle the last bit is on sout.
- Leaving SHIFT at the edge ending the last bit:
  - GAP == 0 and a word is accepted: reload as described under acceptance. The stream continues with no bubble.
  - GAP == 0 and no word is accepted: go to IDLE; sout_valid = 0, sout = IDLE_BIT.
  - GAP > 0: go to GAP with gcnt = 0; sout_valid = 0, sout = IDLE_BIT.
- GAP behaviour:
  - gcnt increments each cycle.
  - When gcnt == GAP-1, go to IDLE. Exactly GAP cycles are spent in GAP.
  - din_ready = 0 throughout.
- IDLE behaviour: sout = IDLE_BIT, sout_valid = 0, word_done = 0.
- din changing outside an accepting edge has no effect. din_valid dropping mid-word has no effect.

## Timing
- Reset values, taking effect on the first edge with RST = 1:
  - state = IDLE; sr, cnt, gcnt = 0.
  - sout = IDLE_BIT, sout_valid = 0, word_done = 0, busy = 0.
  - din_ready is 0 while RST is high.
- Latency: the first bit appears on sout in the cycle after the accepting edge (1 cycle).
- A word occupies exactly WIDTH consecutive sout_valid cycles.
- Sustained throughput:
  - GAP = 0: one bit per cycle, indefinitely, if din_valid is held high.
  - Otherwise: one word per WIDTH+GAP+1 cycles. This includes the IDLE accept cycle when the producer is always valid.
- Reset mid-word:
  - RST wins over every other event.
  - The current word is discarded and word_done does not pulse.
  - The next cycle shows reset values.
- RST high together with din_valid: the word is not accepted.
- Back-to-back boundary: in the last-bit cycle, word_done = 1 and din_ready = 1 simultaneously. The next cycle carries bit 0 of the new word, with word_done = 0.

## Test plan
- Reset: assert RST for 2 cycles with din_valid = 1, din = 8'hFF -> sout = 0, sout_valid = 0, din_ready = 0, busy = 0; nothing is accepted.
- Single word, WIDTH = 8, MSB_FIRST = 1, din = 8'hA5:
  - sout = 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance, with sout_valid high for those 8 cycles.
  - word_done is high only on cycle 8.
  - Cycle 9: sout_valid = 0, busy = 0.
- Back-to-back, GAP = 0: words 8'hA5 then 8'h3C with din_valid held high -> 16 consecutive valid bits 10100101_00111100. word_done pulses on cycles 8 and 16.
- GAP = 2, LSB-first (MSB_FIRST = 0), din = 8'h01 then 8'h80 held valid:
  - Word 1: bits 1,0,0,0,0,0,0,0.
  - Then 2 cycles with sout_valid = 0 and din_ready = 0, then 1 IDLE accept cycle.
  - Word 2: bits 0,0,0,0,0,0,0,1.
- Reset mid-word: accept 8'hFF, assert RST after 3 valid bits -> next cycle sout_valid = 0, sout = IDLE_BIT, no word_done. A following accept of 8'h0F shifts 00001111 normally.
- Integration: feed the word 8'b1001_0010 into the sequence detector -> detector output y pulses on each 0-to-1 transition that follows an earlier 1. For this word that is bit positions 3 and 6, counting the MSB as position 0, each in the cycle that position's bit is on sout.
